hazard_ctrl: RTL

Central hazard controller for the five-stage MIPS pipeline. It inspects the instruction words held in the D, E, M and W pipeline registers and drives three kinds of outputs: stall/flush signals, operand-forwarding selects, and the start/busy sequencing of the multi-cycle multiply/divide unit (MDU). The block sits beside the per-stage control decoders. It owns the only sequential state in the hazard path: the MDU busy counter and a stall performance counter.

---
 rtl/pipeline_defs.sv | 66 ++++++
 rtl/hz_decode.sv | 107 ++++++++++
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline constants for the hazard path: instruction encodings,
// Tuse/Tnew values and forwarding-select encodings.
package pipeline_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BB      = 6'b111111;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef logic [1:0] tval_t;
  localparam tval_t T_0 = 2'd0;
  localparam tval_t T_1 = 2'd1;
  localparam tval_t T_2 = 2'd2;
  // Larger than any Tnew, so an unread operand can never cause a stall
  localparam tval_t TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_D_RF = 2'd0,
    FWD_D_W  = 2'd1,
    FWD_D_M  = 2'd2,
    FWD_D_E  = 2'd3
  } fwd_d_e;

  typedef enum logic [1:0] {
    FWD_E_PIPE = 2'd0,
    FWD_E_W    = 2'd1,
    FWD_E_M    = 2'd2
  } fwd_e_e;

  localparam logic FWD_M_PIPE = 1'b0;
  localparam logic FWD_M_W    = 1'b1;

  // Tnew seen ofs stages after E, saturating at zero
  function automatic tval_t tnew_age(input tval_t t, input int unsigned ofs);
    tval_t r;
    if (ofs >= 32'd2) begin
      r = T_0;
    end else if (ofs == 32'd1) begin
      r = (t == T_0) ? T_0 : t - 2'd1;
    end else begin
      r = t;
    end
    return r;
  endfunction

endpackage

// File: rtl/hz_decode.sv
// Per-stage field extraction: register fields, destination, Tuse and the
// stage-relative Tnew of one instruction word.
module hz_decode import pipeline_defs::*; #(
  parameter int unsigned STAGE_OFS = 0
) (
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output tval_t       tuse_rs,
  output tval_t       tuse_rt,
  output tval_t       tnew,
  output logic        is_md,
  output logic        is_md_start
);

  logic [5:0] op_s;
  logic [5:0] fn_s;
  logic [4:0] rd_s;
  logic [4:0] dst_raw_s;
  tval_t      tnew_e_s;

  assign op_s = instr[31:26];
  assign fn_s = instr[5:0];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd_s = instr[15:11];

  // Classify the instruction; tnew_e_s is the value while it sits in E
  always_comb begin
    dst_raw_s   = REG_ZERO;
    tuse_rs     = TUSE_NONE;
    tuse_rt     = TUSE_NONE;
    tnew_e_s    = T_0;
    is_md       = 1'b0;
    is_md_start = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        case (fn_s)
          FN_ADDU, FN_SUBU: begin
            dst_raw_s = rd_s;
            tuse_rs   = T_1;
            tuse_rt   = T_1;
            tnew_e_s  = T_1;
          end
          FN_JR: begin
            tuse_rs = T_0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            tuse_rs     = T_1;
            tuse_rt     = T_1;
            is_md       = 1'b1;
            is_md_start = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dst_raw_s = rd_s;
            tnew_e_s  = T_1;
            is_md     = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs = T_1;
            is_md   = 1'b1;
          end
          default: begin
            dst_raw_s = REG_ZERO;
          end
        endcase
      end
      OP_ORI: begin
        dst_raw_s = rt;
        tuse_rs   = T_1;
        tnew_e_s  = T_1;
      end
      OP_LUI: begin
        dst_raw_s = rt;
        tnew_e_s  = T_1;
      end
      OP_LW: begin
        dst_raw_s = rt;
        tuse_rs   = T_1;
        tnew_e_s  = T_2;
      end
      OP_SW: begin
        tuse_rs = T_1;
        tuse_rt = T_2;
      end
      OP_BEQ: begin
        tuse_rs = T_0;
        tuse_rt = T_0;
      end
      OP_JAL, OP_BB: begin
        dst_raw_s = REG_RA;
        tnew_e_s  = T_0;
      end
      OP_J: begin
        dst_raw_s = REG_ZERO;
      end
      default: begin
        dst_raw_s = REG_ZERO;
      end
    endcase
  end

  assign dst  = dst_raw_s;
  assign tnew = tnew_age(tnew_e_s, STAGE_OFS);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stall/flush, operand forwarding selects, MDU
// start/busy sequencing and a saturating stall counter.
module hazard_ctrl import pipeline_defs::*; #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_M,
  input  logic [31:0] instr_W,
  output logic        stall_PC,
  output logic        stall_D,
  output logic        flush_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [4:0] rs_d_s, rt_d_s, dst_d_s;
  logic [4:0] rs_e_s, rt_e_s, dst_e_s;
  logic [4:0] rs_m_s, rt_m_s, dst_m_s;
  logic [4:0] rs_w_s, rt_w_s, dst_w_s;
  tval_t      tuse_rs_d_s, tuse_rt_d_s, tnew_d_s;
  tval_t      tuse_rs_e_s, tuse_rt_e_s, tnew_e_s;
  tval_t      tuse_rs_m_s, tuse_rt_m_s, tnew_m_s;
  tval_t      tuse_rs_w_s, tuse_rt_w_s, tnew_w_s;
  logic       is_md_d_s, is_md_e_s, is_md_m_s, is_md_w_s;
  logic       start_d_s, start_e_s, start_m_s, start_w_s;

  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      stall_cnt_r;
  logic             data_stall_s;
  logic             md_stall_s;
  logic             stall_s;
  logic             md_busy_s;
  logic             is_div_e_s;
  logic [1:0]       fwd_rs_e_s, fwd_rt_e_s;
  logic             fwd_rt_m_s;
  logic             unused_dec_s;

  hz_decode #(.STAGE_OFS(0)) u_dec_d (
    .instr(instr_D), .rs(rs_d_s), .rt(rt_d_s), .dst(dst_d_s),
    .tuse_rs(tuse_rs_d_s), .tuse_rt(tuse_rt_d_s), .tnew(tnew_d_s),
    .is_md(is_md_d_s), .is_md_start(start_d_s)
  );
  hz_decode #(.STAGE_OFS(0)) u_dec_e (
    .instr(instr_E), .rs(rs_e_s), .rt(rt_e_s), .dst(dst_e_s),
    .tuse_rs(tuse_rs_e_s), .tuse_rt(tuse_rt_e_s), .tnew(tnew_e_s),
    .is_md(is_md_e_s), .is_md_start(start_e_s)
  );
  hz_decode #(.STAGE_OFS(1)) u_dec_m (
    .instr(instr_M), .rs(rs_m_s), .rt(rt_m_s), .dst(dst_m_s),
    .tuse_rs(tuse_rs_m_s), .tuse_rt(tuse_rt_m_s), .tnew(tnew_m_s),
    .is_md(is_md_m_s), .is_md_start(start_m_s)
  );
  hz_decode #(.STAGE_OFS(2)) u_dec_w (
    .instr(instr_W), .rs(rs_w_s), .rt(rt_w_s), .dst(dst_w_s),
    .tuse_rs(tuse_rs_w_s), .tuse_rt(tuse_rt_w_s), .tnew(tnew_w_s),
    .is_md(is_md_w_s), .is_md_start(start_w_s)
  );

  assign unused_dec_s = ^{tnew_d_s, start_d_s, tuse_rs_e_s, tuse_rt_e_s, is_md_e_s,
                          rs_m_s, tuse_rs_m_s, tuse_rt_m_s, is_md_m_s, start_m_s,
                          rs_w_s, rt_w_s, tuse_rs_w_s, tuse_rt_w_s, is_md_w_s, start_w_s};

  // A producer still computing r when the D reader needs it
  function automatic logic late_producer(input logic [4:0] r, input tval_t tuse,
                                         input logic [4:0] dst, input tval_t tnew);
    return (r != REG_ZERO) && (dst == r) && (tnew > tuse);
  endfunction

  // Youngest ready producer for a D-stage compare operand
  function automatic logic [1:0] sel_d(input logic [4:0] r);
    logic [1:0] s;
    if (r == REG_ZERO) begin
      s = FWD_D_RF;
    end else if ((dst_e_s == r) && (tnew_e_s == T_0)) begin
      s = FWD_D_E;
    end else if ((dst_m_s == r) && (tnew_m_s == T_0)) begin
      s = FWD_D_M;
    end else if ((dst_w_s == r) && (tnew_w_s == T_0)) begin
      s = FWD_D_W;
    end else begin
      s = FWD_D_RF;
    end
    return s;
  endfunction

  // Youngest ready producer for an E-stage ALU operand
  function automatic logic [1:0] sel_e(input logic [4:0] r);
    logic [1:0] s;
    if (r == REG_ZERO) begin
      s = FWD_E_PIPE;
    end else if ((dst_m_s == r) && (tnew_m_s == T_0)) begin
      s = FWD_E_M;
    end else if ((dst_w_s == r) && (tnew_w_s == T_0)) begin
      s = FWD_E_W;
    end else begin
      s = FWD_E_PIPE;
    end
    return s;
  endfunction

  assign data_stall_s = late_producer(rs_d_s, tuse_rs_d_s, dst_e_s, tnew_e_s)
                      | late_producer(rt_d_s, tuse_rt_d_s, dst_e_s, tnew_e_s)
                      | late_producer(rs_d_s, tuse_rs_d_s, dst_m_s, tnew_m_s)
                      | late_producer(rt_d_s, tuse_rt_d_s, dst_m_s, tnew_m_s);

  assign md_busy_s  = start_e_s | (cnt_r != '0);
  assign md_stall_s = is_md_d_s & md_busy_s;
  assign stall_s    = data_stall_s | md_stall_s;
  assign is_div_e_s = (instr_E[5:0] == FN_DIV) || (instr_E[5:0] == FN_DIVU);

  // E and M stage forwarding selects
  always_comb begin
    fwd_rs_e_s = sel_e(rs_e_s);
    fwd_rt_e_s = sel_e(rt_e_s);
    fwd_rt_m_s = FWD_M_PIPE;
    if ((rt_m_s != REG_ZERO) && (dst_w_s == rt_m_s)) begin
      fwd_rt_m_s = FWD_M_W;
    end else begin
      fwd_rt_m_s = FWD_M_PIPE;
    end
  end

  // MDU occupancy: load the latency on start, then count down to idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (start_e_s) begin
      cnt_r <= is_div_e_s ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_PC  = stall_s;
  assign stall_D   = stall_s;
  assign flush_E   = stall_s;
  assign fwd_rs_D  = sel_d(rs_d_s);
  assign fwd_rt_D  = sel_d(rt_d_s);
  assign fwd_rs_E  = fwd_rs_e_s;
  assign fwd_rt_E  = fwd_rt_e_s;
  assign fwd_rt_M  = fwd_rt_m_s;
  assign md_start  = start_e_s;
  assign md_busy   = md_busy_s;
  assign stall_cnt = stall_cnt_r;

endmodule
